board_icap_reader: RTL and testbench

Readback engine for the 7-series configuration port. It is the read-side counterpart of the warm-boot writer. On a start request it drives the ICAPE2 interface through the sync/read-command/readback sequence and returns one 32-bit configuration register, for example IDCODE, BOOTSTS or STAT, to board logic. The ICAP pins are exposed as ports; a board wrapper connects them to the single ICAPE2 instance, so the block can be simulated against a bench model.

---
 rtl/board_icap_reader.sv | 201 ++++++++++++++++++++
 tb/tb_board_icap_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_icap_reader.sv
// rtl/board_icap_reader.sv - ICAPE2 configuration register readback engine
//
// Purpose: on a start request, drives the ICAPE2 pins through dummy/sync/
// read-command words, switches the port to read mode, captures one 32-bit
// configuration register, switches back to write mode and pulses done.
// Optional macro BOARD_ICAP_DESYNC_EN appends a DESYNC command sequence so the
// ICAP is released desynchronised.
//
// Ports:
//   Clk         system clock (also ICAPE2 CLK in the board wrapper)
//   Reset       synchronous, active-high
//   start       read request, sampled only while idle
//   reg_addr    configuration register address, latched at start
//   busy        sequence in progress
//   done        one-cycle pulse, data valid
//   data        captured register value (un-bitswapped)
//   icap_csib   ICAPE2 CSIB, active-low select
//   icap_rdwrb  ICAPE2 RDWRB, 0 = write, 1 = read
//   icap_i      ICAPE2 I, bitswapped write word
//   icap_o      ICAPE2 O, bitswapped read word

module board_icap_reader #(
  parameter int READ_WAIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [4:0]  reg_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] data,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WRITE,
    S_SW_R1,
    S_SW_R2,
    S_READ,
    S_SW_W1,
    S_SW_W2,
    S_DESYNC,
    S_DONE
  } state_t;

  localparam logic [3:0] WRITE_LAST  = 4'd6;
  localparam logic [3:0] READ_LAST   = 4'(READ_WAIT - 1);
  localparam logic [3:0] DESYNC_LAST = 4'd3;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [4:0]  addr_q, addr_n;
  logic        capture;
  logic        csib_n, rdwrb_n, busy_n, done_n;
  logic [31:0] icap_i_n;

  // ICAP data pins are bit-reversed within each byte; byte order is kept.
  function automatic logic [31:0] bitswap(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = w[i ^ 7];
    end
    return r;
  endfunction

  // Dummy, sync, two NOOPs, type-1 read of one word, two NOOPs.
  function automatic logic [31:0] write_word(input logic [3:0] idx, input logic [4:0] a);
    case (idx)
      4'd0:    return 32'hFFFF_FFFF;
      4'd1:    return 32'hAA99_5566;
      4'd4:    return 32'h2800_0001 | {14'd0, a, 13'd0};
      default: return 32'h2000_0000;
    endcase
  endfunction

  // Write CMD register with DESYNC code, then two NOOPs.
  function automatic logic [31:0] desync_word(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'h3000_8001;
      4'd1:    return 32'h0000_000D;
      default: return 32'h2000_0000;
    endcase
  endfunction

  // Next state. Outputs are then decoded from the next state so that every
  // output is a register aligned with the state it belongs to.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WRITE;
          cnt_n   = 4'd0;
          addr_n  = reg_addr;
        end
      end
      S_WRITE: begin
        if (cnt == WRITE_LAST) begin
          state_n = S_SW_R1;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_SW_R1: state_n = S_SW_R2;
      S_SW_R2: begin
        state_n = S_READ;
        cnt_n   = 4'd0;
      end
      S_READ: begin
        if (cnt == READ_LAST) begin
          capture = 1'b1;
          state_n = S_SW_W1;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_SW_W1: state_n = S_SW_W2;
      S_SW_W2: begin
`ifdef BOARD_ICAP_DESYNC_EN
        state_n = S_DESYNC;
        cnt_n   = 4'd0;
`else
        state_n = S_DONE;
`endif
      end
      S_DESYNC: begin
        if (cnt == DESYNC_LAST) begin
          state_n = S_DONE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // RDWRB only ever changes in a state where CSIB is high (SW_* / DONE), so
  // the port direction is never switched while selected.
  always_comb begin
    csib_n   = 1'b1;
    rdwrb_n  = 1'b1;
    icap_i_n = 32'd0;
    busy_n   = (state_n != S_IDLE);
    done_n   = 1'b0;
    case (state_n)
      S_WRITE: begin
        csib_n   = 1'b0;
        rdwrb_n  = 1'b0;
        icap_i_n = bitswap(write_word(cnt_n, addr_n));
      end
      S_SW_R1: rdwrb_n = 1'b0;
      S_READ:  csib_n  = 1'b0;
      S_SW_W2: rdwrb_n = 1'b0;
      S_DESYNC: begin
        csib_n   = 1'b0;
        rdwrb_n  = 1'b0;
        icap_i_n = bitswap(desync_word(cnt_n));
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      addr_q     <= 5'd0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data       <= 32'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      addr_q     <= addr_n;
      icap_csib  <= csib_n;
      icap_rdwrb <= rdwrb_n;
      icap_i     <= icap_i_n;
      busy       <= busy_n;
      done       <= done_n;
      if (capture) begin
        data <= bitswap(icap_o);
      end
    end
  end

endmodule

// File: tb/tb_board_icap_reader.sv
// tb/tb_board_icap_reader.sv - scoreboard bench for board_icap_reader

module tb_board_icap_reader;

`ifdef BOARD_ICAP_DESYNC_EN
  localparam int DES = 4;
`else
  localparam int DES = 0;
`endif
  localparam int RW  = 4;
  localparam int LAT = 11 + RW + DES;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  reg_addr = 5'd0;
  logic        busy, done, icap_csib, icap_rdwrb;
  logic [31:0] data, icap_i, icap_o;

  logic        start_aux = 1'b0;
  logic [4:0]  addr_aux = 5'h0C;
  logic        w1_busy, w1_done, w1_csib, w1_rdwrb;
  logic [31:0] w1_data, w1_i, w1_o;
  logic        w8_busy, w8_done, w8_csib, w8_rdwrb;
  logic [31:0] w8_data, w8_i, w8_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int w1_cyc = -1;
  int w8_cyc = -1;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  board_icap_reader dut (
    .Clk(Clk), .Reset(Reset), .start(start), .reg_addr(reg_addr),
    .busy(busy), .done(done), .data(data),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_o(icap_o)
  );

  board_icap_reader #(.READ_WAIT(1)) dut_w1 (
    .Clk(Clk), .Reset(Reset), .start(start_aux), .reg_addr(addr_aux),
    .busy(w1_busy), .done(w1_done), .data(w1_data),
    .icap_csib(w1_csib), .icap_rdwrb(w1_rdwrb), .icap_i(w1_i), .icap_o(w1_o)
  );

  board_icap_reader #(.READ_WAIT(8)) dut_w8 (
    .Clk(Clk), .Reset(Reset), .start(start_aux), .reg_addr(addr_aux),
    .busy(w8_busy), .done(w8_done), .data(w8_data),
    .icap_csib(w8_csib), .icap_rdwrb(w8_rdwrb), .icap_i(w8_i), .icap_o(w8_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b+k] = w[8*b+7-k];
    return r;
  endfunction

  // Register contents as presented on the (bitswapped) O pins.
  function automatic logic [31:0] reg_val(input logic [4:0] a);
    case (a)
      5'h0C:   return 32'hC0C6_08C9;
      5'h16:   return 32'h1E2D_3C4B;
      default: return {a, 27'h0000ABC};
    endcase
  endfunction

  // ICAP model: decode the type-1 read header from the write stream.
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_word;
  assign m_word = bswap(icap_i);
  always @(posedge Clk)
    if (!icap_csib && !icap_rdwrb && m_word[31:27] == 5'b00101 && m_word[10:0] == 11'd1)
      m_addr <= m_word[17:13];
  assign icap_o = (!icap_csib && icap_rdwrb) ? reg_val(m_addr) : 32'h0BAD_F00D;
  assign w1_o   = (!w1_csib && w1_rdwrb) ? 32'hC0C6_08C9 : 32'h0BAD_F00D;
  assign w8_o   = (!w8_csib && w8_rdwrb) ? 32'hC0C6_08C9 : 32'h0BAD_F00D;

  typedef struct { logic [31:0] d; int c; } exp_t;
  logic [31:0] wq[$];
  exp_t        dq[$];

  task automatic push_req(input logic [4:0] a, input int e0);
    exp_t e;
    wq.push_back(bswap(32'hFFFF_FFFF));
    wq.push_back(bswap(32'hAA99_5566));
    wq.push_back(bswap(32'h2000_0000));
    wq.push_back(bswap(32'h2000_0000));
    wq.push_back(bswap(32'h2800_0001 | (32'(a) << 13)));
    wq.push_back(bswap(32'h2000_0000));
    wq.push_back(bswap(32'h2000_0000));
    if (DES != 0) begin
      wq.push_back(bswap(32'h3000_8001));
      wq.push_back(bswap(32'h0000_000D));
      wq.push_back(bswap(32'h2000_0000));
      wq.push_back(bswap(32'h2000_0000));
    end
    e.d = bswap(reg_val(a));
    e.c = e0 + LAT;
    dq.push_back(e);
  endtask

  // Scoreboard monitor.
  logic prev_csib = 1'b1;
  logic prev_rdwrb = 1'b1;
  always @(negedge Clk) begin
    if (!icap_csib && !icap_rdwrb) begin
      if (wq.size() == 0) check("wr_pending", 32'(wq.size()), 32'd1);
      else check("icap_i", icap_i, wq.pop_front());
    end
    if (done) begin
      done_cnt++;
      if (dq.size() == 0) check("done_pending", 32'(dq.size()), 32'd1);
      else begin
        check("data", data, dq[0].d);
        check("done_edge", 32'(cyc), 32'(dq[0].c));
        void'(dq.pop_front());
      end
    end
    if (!icap_csib && !prev_csib) check("rdwrb_hold", 32'(icap_rdwrb), 32'(prev_rdwrb));
    prev_csib  <= icap_csib;
    prev_rdwrb <= icap_rdwrb;
    if (w1_done) w1_cyc <= cyc;
    if (w8_done) w8_cyc <= cyc;
  end

  function automatic logic [1:0] phase(input int k);
    if (k <= 6) return 2'b00;
    if (k == 7) return 2'b10;
    if (k == 8) return 2'b11;
    if (k <= 8 + RW) return 2'b01;
    if (k == 9 + RW) return 2'b11;
    if (k == 10 + RW) return 2'b10;
    if (k <= 10 + RW + DES) return 2'b00;
    return 2'b11;
  endfunction

  // Called right after start is driven; checks {csib,rdwrb} every cycle.
  task automatic trace_seq(input int e0);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge Clk);
      start = 1'b0;
      check($sformatf("hs_e%0d", k), 32'({icap_csib, icap_rdwrb}), 32'(phase(k)));
      if (cyc != e0 + k) check("trace_align", 32'(cyc), 32'(e0 + k));
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int e0;
    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_csib", 32'(icap_csib), 32'd1);
    check("rst_rdwrb", 32'(icap_rdwrb), 32'd1);
    check("rst_icap_i", icap_i, 32'd0);
    check("rst_data", data, 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // IDCODE read with full handshake trace
    reg_addr = 5'h0C;
    start = 1'b1;
    e0 = cyc + 1;
    push_req(5'h0C, e0);
    trace_seq(e0);
    wait_done(1, 10);
    check("idcode", data, 32'h0363_1093);
    repeat (3) @(negedge Clk);

    // Busy rejection: second start with another address is ignored
    reg_addr = 5'h0C;
    start = 1'b1;
    e0 = cyc + 1;
    push_req(5'h0C, e0);
    @(negedge Clk);
    start = 1'b0;
    while (cyc < e0 + 4) @(negedge Clk);
    reg_addr = 5'h16;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_done(2, 40);
    repeat (8) @(negedge Clk);
    check("busy_rej_data", data, 32'h0363_1093);
    check("busy_rej_cnt", 32'(done_cnt), 32'd2);

    // Back-to-back with start held high; address changes mid-sequence
    reg_addr = 5'h0C;
    start = 1'b1;
    e0 = cyc + 1;
    push_req(5'h0C, e0);
    push_req(5'h16, e0 + LAT + 2);
    @(negedge Clk);
    reg_addr = 5'h16;
    while (cyc < e0 + LAT + 1) @(negedge Clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_first_data", data, 32'h0363_1093);
    @(negedge Clk);
    start = 1'b0;
    check("b2b_restart_busy", 32'(busy), 32'd1);
    wait_done(4, 40);
    check("b2b_second_data", data, bswap(32'h1E2D_3C4B));

    // Reset during READ aborts with no done
    repeat (2) @(negedge Clk);
    reg_addr = 5'h0C;
    start = 1'b1;
    e0 = cyc + 1;
    push_req(5'h0C, e0);
    @(negedge Clk);
    start = 1'b0;
    while (cyc < e0 + 10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_csib", 32'(icap_csib), 32'd1);
    check("abort_rdwrb", 32'(icap_rdwrb), 32'd1);
    check("abort_icap_i", icap_i, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", data, 32'd0);
    wq.delete();
    dq.delete();
    repeat (3) @(negedge Clk);
    check("abort_no_done", 32'(done_cnt), 32'd4);
    reg_addr = 5'h16;
    start = 1'b1;
    e0 = cyc + 1;
    push_req(5'h16, e0);
    trace_seq(e0);
    wait_done(5, 10);
    check("recover_data", data, bswap(32'h1E2D_3C4B));

    // READ_WAIT = 1 and 8 latency
    repeat (2) @(negedge Clk);
    start_aux = 1'b1;
    e0 = cyc + 1;
    @(negedge Clk);
    start_aux = 1'b0;
    for (int n = 0; n < 40 && w8_cyc < 0; n++) @(negedge Clk);
    check("w1_done_edge", 32'(w1_cyc - e0), 32'(12 + DES));
    check("w8_done_edge", 32'(w8_cyc - e0), 32'(19 + DES));
    check("w1_data", w1_data, 32'h0363_1093);
    check("w8_data", w8_data, 32'h0363_1093);

    repeat (3) @(negedge Clk);
    check("wq_left", 32'(wq.size()), 32'd0);
    check("dq_left", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
